otter_imm_gen_stage: RTL



---
 rtl/otter_imm_gen_stage_pkg.sv | 38 +++
 rtl/otter_imm_gen_stage_if.sv | 28 ++
 rtl/otter_skid_buf.sv | 44 ++++
 rtl/otter_imm_gen_stage.sv | 74 +++++++
 4 files changed

// File: rtl/otter_imm_gen_stage_pkg.sv
// Shared decode definitions: immediate selector codes and the format mux used by decode and the imm-gen stage.
package otter_imm_gen_stage_pkg;

   typedef enum logic [2:0] {
      IMM_GEN_SEL_UPPER    = 3'd0,
      IMM_GEN_SEL_I_TYPE   = 3'd1,
      IMM_GEN_SEL_S_TYPE   = 3'd2,
      IMM_GEN_SEL_BRANCH   = 3'd3,
      IMM_GEN_SEL_JUMP     = 3'd4,
      IMM_GEN_SEL_CSR_ZIMM = 3'd5,
      IMM_GEN_SEL_SHAMT    = 3'd6,
      IMM_GEN_SEL_RSVD     = 3'd7
   } imm_sel_e;

   // Always expands to 64 bits; narrower datapaths truncate, which keeps sign extension correct.
   function automatic logic [63:0] imm_expand(input logic [31:0] instrn, input logic [2:0] sel);
      logic [63:0] imm;
      imm = '0;
      case (imm_sel_e'(sel))
         IMM_GEN_SEL_UPPER:    imm = {{32{instrn[31]}}, instrn[31:12], 12'b0};
         IMM_GEN_SEL_I_TYPE:   imm = {{52{instrn[31]}}, instrn[31:20]};
         IMM_GEN_SEL_S_TYPE:   imm = {{52{instrn[31]}}, instrn[31:25], instrn[11:7]};
         IMM_GEN_SEL_BRANCH:   imm = {{51{instrn[31]}}, instrn[31], instrn[7], instrn[30:25],
                                      instrn[11:8], 1'b0};
         IMM_GEN_SEL_JUMP:     imm = {{43{instrn[31]}}, instrn[31], instrn[19:12], instrn[20],
                                      instrn[30:21], 1'b0};
         IMM_GEN_SEL_CSR_ZIMM: imm = {59'b0, instrn[19:15]};
         IMM_GEN_SEL_SHAMT:    imm = {58'b0, instrn[25:20]};
         default:              imm = '0;
      endcase
      return imm;
   endfunction

   function automatic logic imm_sel_reserved(input logic [2:0] sel);
      return sel == IMM_GEN_SEL_RSVD;
   endfunction

endpackage

// File: rtl/otter_imm_gen_stage_if.sv
// Handshake bundle between decode (master) and the imm-gen stage (slave) plus its execute-side outputs.
interface otter_imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             i_valid;
   logic             o_ready;
   logic [31:0]      i_instrn;
   logic [2:0]       i_imm_sel;
   logic [XLEN-1:0]  i_pc;
   logic [TAG_W-1:0] i_tag;
   logic             o_valid;
   logic             i_ready;
   logic [XLEN-1:0]  o_immed;
   logic [XLEN-1:0]  o_target;
   logic [TAG_W-1:0] o_tag;
   logic             o_illegal;

   modport master (
      output i_valid, i_instrn, i_imm_sel, i_pc, i_tag, i_ready,
      input  o_ready, o_valid, o_immed, o_target, o_tag, o_illegal
   );

   modport slave (
      input  i_valid, i_instrn, i_imm_sel, i_pc, i_tag, i_ready,
      output o_ready, o_valid, o_immed, o_target, o_tag, o_illegal
   );
endinterface

// File: rtl/otter_skid_buf.sv
// Generic one-entry skid buffer: registered output slot plus one parking slot; s_ready depends only on state.
module otter_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data
);
   logic         skid_vld;
   logic [W-1:0] skid_data;
   logic         s_fire;
   logic         m_stall;

   assign s_ready = !skid_vld && !rst;
   assign s_fire  = s_valid && s_ready;
   assign m_stall = m_valid && !m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b0;
         m_data    <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
      end else if (m_stall) begin
         // Output held: a new arrival can only go to the parking slot.
         if (s_fire) begin
            skid_vld  <= 1'b1;
            skid_data <= s_data;
         end
      end else if (skid_vld) begin
         m_valid  <= 1'b1;
         m_data   <= skid_data;
         skid_vld <= 1'b0;
      end else begin
         m_valid <= s_fire;
         if (s_fire) m_data <= s_data;
      end
   end
endmodule

// File: rtl/otter_imm_gen_stage.sv
// Registered immediate-generation stage: immediate, pc+imm target, tag passthrough, reserved-selector flag.
// Define OTTER_IMM_GEN_SKID_EN for a skid buffer giving a registered o_ready at full throughput.
module otter_imm_gen_stage
   import otter_imm_gen_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input logic                  i_clk,
   input logic                  i_rst,
   otter_imm_gen_stage_if.slave bus
);
   logic [XLEN-1:0]  imm_in;
   logic             ill_in;
   logic             out_vld;
   logic [XLEN-1:0]  imm_q;
   logic [XLEN-1:0]  pc_q;
   logic [TAG_W-1:0] tag_q;
   logic             ill_q;

   assign imm_in = XLEN'(imm_expand(bus.i_instrn, bus.i_imm_sel));
   assign ill_in = imm_sel_reserved(bus.i_imm_sel);

`ifdef OTTER_IMM_GEN_SKID_EN
   localparam int PW = 2*XLEN + TAG_W + 1;
   logic [PW-1:0] in_pl;
   logic [PW-1:0] out_pl;

   assign in_pl = {imm_in, bus.i_pc, bus.i_tag, ill_in};

   otter_skid_buf #(.W(PW)) u_skid (
      .clk     (i_clk),
      .rst     (i_rst),
      .s_valid (bus.i_valid),
      .s_ready (bus.o_ready),
      .s_data  (in_pl),
      .m_valid (out_vld),
      .m_ready (bus.i_ready),
      .m_data  (out_pl)
   );

   assign {imm_q, pc_q, tag_q, ill_q} = out_pl;
`else
   logic accept;

   assign bus.o_ready = !i_rst && (!out_vld || bus.i_ready);
   assign accept      = bus.i_valid && bus.o_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_vld <= 1'b0;
         imm_q   <= '0;
         pc_q    <= '0;
         tag_q   <= '0;
         ill_q   <= 1'b0;
      end else if (accept) begin
         out_vld <= 1'b1;
         imm_q   <= imm_in;
         pc_q    <= bus.i_pc;
         tag_q   <= bus.i_tag;
         ill_q   <= ill_in;
      end else if (bus.i_ready) begin
         out_vld <= 1'b0;
      end
   end
`endif

   // Target added after the register so the adder sits in the execute-side half of the cycle.
   assign bus.o_valid   = out_vld;
   assign bus.o_immed   = imm_q;
   assign bus.o_target  = pc_q + imm_q;
   assign bus.o_tag     = tag_q;
   assign bus.o_illegal = ill_q;
endmodule
